// File: rtl/polyphase_pkg.sv
// -----------------------------------------------------------------------------
// polyphase_pkg
// Shared definitions for the decimating folded-FIR operand sequencer:
//   state_e      - sequencer FSM states (FILL, ISSUE, WAIT, OUTPUT)
//   folded_taps  - number of folded taps T = (N+1)/2 for an odd filter length N
// -----------------------------------------------------------------------------
package polyphase_pkg;

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_OUTPUT = 2'd3
   } state_e;

   // A symmetric odd-length filter folds into (N-1)/2 pairs plus the centre tap.
   function automatic int folded_taps(input int n);
      return (n + 1) / 2;
   endfunction

endpackage

// File: rtl/tap_delay_line.sv
// -----------------------------------------------------------------------------
// tap_delay_line
// N-entry sample shift register with two independent parallel read ports.
// Entry 0 holds the newest sample, entry N-1 the oldest.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   shift_en              - push din into entry 0 and age every other entry
//   din         [W-1:0]   - sample to push
//   rd_addr_a/b [AW-1:0]  - read indices
//   rd_data_a/b [W-1:0]   - entries at those indices
// -----------------------------------------------------------------------------
module tap_delay_line #(
   parameter int W  = 16,
   parameter int N  = 31,
   localparam int AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          shift_en,
   input  logic [W-1:0]  din,
   input  logic [AW-1:0] rd_addr_a,
   input  logic [AW-1:0] rd_addr_b,
   output logic [W-1:0]  rd_data_a,
   output logic [W-1:0]  rd_data_b
);

   logic [W-1:0] x_q [N];
   logic [W-1:0] x_d [N];

   // NOTE: every always_comb output gets a default before any condition, so no path can infer a latch.
   always_comb begin
      x_d = x_q;
      if (shift_en) begin
         x_d[0] = din;
         for (int i = 1; i < N; i++) begin
            x_d[i] = x_q[i-1];
         end
      end
   end

   // NOTE: this array is reset on purpose: the first outputs after reset must see a zero sample history, not stale data.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            x_q[i] <= '0;
         end
      end else begin
         x_q <= x_d;
      end
   end

   assign rd_data_a = x_q[rd_addr_a];
   assign rd_data_b = x_q[rd_addr_b];

endmodule

// File: rtl/mac_operand_sequencer.sv
// -----------------------------------------------------------------------------
// mac_operand_sequencer
// Feeds an external multiply-accumulate unit computing (s1+s2)*s3+s4 to realise
// a symmetric (folded) N-tap FIR filter decimating by M.  For every M accepted
// samples it issues T = (N+1)/2 MAC operations, chaining each result into the
// next as the accumulator, and emits the final sum as y_data.
// Ports:
//   clk, reset                    - clock, asynchronous active-high reset
//   sample_in/valid, sample_ready - sample input handshake
//   coef_we/addr/data             - coefficient write port (any state)
//   valid_in, signal_1..4         - operand set to the MAC, held until valid_out
//   valid_out, data_out           - MAC result handshake
//   y_valid, y_data               - one-cycle filtered output strobe
//   error                         - sticky flag: a MAC operation timed out
// -----------------------------------------------------------------------------
module mac_operand_sequencer
   import polyphase_pkg::*;
#(
   parameter int SAMPLE_WIDTH = 16,
   parameter int N            = 31,
   parameter int M            = 2,
   parameter int TIMEOUT      = 64,
   localparam int T           = folded_taps(N),
   localparam int CW          = $clog2(T)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [SAMPLE_WIDTH-1:0] sample_in,
   input  logic                    sample_valid,
   output logic                    sample_ready,
   input  logic                    coef_we,
   input  logic [CW-1:0]           coef_addr,
   input  logic [SAMPLE_WIDTH-1:0] coef_data,
   output logic                    valid_in,
   output logic [SAMPLE_WIDTH-1:0] signal_1,
   output logic [SAMPLE_WIDTH-1:0] signal_2,
   output logic [SAMPLE_WIDTH-1:0] signal_3,
   output logic [SAMPLE_WIDTH-1:0] signal_4,
   input  logic                    valid_out,
   input  logic [SAMPLE_WIDTH-1:0] data_out,
   output logic                    y_valid,
   output logic [SAMPLE_WIDTH-1:0] y_data,
   output logic                    error
);

   localparam int W  = SAMPLE_WIDTH;
   localparam int AW = $clog2(N);
   localparam int PW = (M > 1) ? $clog2(M) : 1;
   localparam int WW = $clog2(TIMEOUT + 1);

   state_e          state_q, state_d;
   logic [PW-1:0]   p_q, p_d;
   logic [CW-1:0]   k_q, k_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [WW-1:0]   wait_q, wait_d;
   logic            valid_in_q, valid_in_d;
   logic [W-1:0]    signal_1_q, signal_1_d;
   logic [W-1:0]    signal_2_q, signal_2_d;
   logic [W-1:0]    signal_3_q, signal_3_d;
   logic [W-1:0]    signal_4_q, signal_4_d;
   logic            y_valid_q, y_valid_d;
   logic [W-1:0]    y_data_q, y_data_d;
   logic            error_q, error_d;
   logic [W-1:0]    coef_q [T];
   logic [W-1:0]    coef_d [T];

   logic            sample_accept;
   logic [W-1:0]    x_near, x_far;

   assign sample_ready  = (state_q == ST_FILL);
   assign sample_accept = sample_valid && sample_ready;

   // Folded pair for tap k is x[k] and its mirror x[N-1-k].
   tap_delay_line #(
      .W (W),
      .N (N)
   ) u_delay (
      .clk       (clk),
      .reset     (reset),
      .shift_en  (sample_accept),
      .din       (sample_in),
      .rd_addr_a (AW'(k_q)),
      .rd_addr_b (AW'(N - 1) - AW'(k_q)),
      .rd_data_a (x_near),
      .rd_data_b (x_far)
   );

   // Coefficient store: writable in any state; ISSUE reads coef_q, so a write
   // landing on the same edge is seen only by later taps.
   always_comb begin
      coef_d = coef_q;
      if (coef_we && ({1'b0, coef_addr} < (CW + 1)'(T))) begin
         coef_d[coef_addr] = coef_data;
      end
   end

   always_comb begin
      state_d    = state_q;
      p_d        = p_q;
      k_d        = k_q;
      acc_d      = acc_q;
      wait_d     = wait_q;
      valid_in_d = valid_in_q;
      signal_1_d = signal_1_q;
      signal_2_d = signal_2_q;
      signal_3_d = signal_3_q;
      signal_4_d = signal_4_q;
      y_valid_d  = 1'b0;
      y_data_d   = y_data_q;
      error_d    = error_q;

      case (state_q)
         ST_FILL: begin
            if (sample_accept) begin
               if (p_q == PW'(M - 1)) begin
                  p_d     = '0;
                  k_d     = '0;
                  acc_d   = '0;
                  state_d = ST_ISSUE;
               end else begin
                  p_d = p_q + PW'(1);
               end
            end
         end

         ST_ISSUE: begin
            signal_1_d = x_near;
            // The centre tap has no mirror partner; zero keeps it counted once.
            signal_2_d = (k_q == CW'(T - 1)) ? '0 : x_far;
            signal_3_d = coef_q[k_q];
            signal_4_d = acc_q;
            valid_in_d = 1'b1;
            wait_d     = '0;
            state_d    = ST_WAIT;
         end

         ST_WAIT: begin
            if (valid_out) begin
               acc_d      = data_out;
               valid_in_d = 1'b0;
               if (k_q == CW'(T - 1)) begin
                  y_valid_d = 1'b1;
                  y_data_d  = data_out;
                  state_d   = ST_OUTPUT;
               end else begin
                  k_d     = k_q + CW'(1);
                  state_d = ST_ISSUE;
               end
            end else if (wait_q == WW'(TIMEOUT - 1)) begin
               // MAC never answered: drop this output and resynchronise phase.
               error_d    = 1'b1;
               valid_in_d = 1'b0;
               p_d        = '0;
               state_d    = ST_FILL;
            end else begin
               wait_d = wait_q + WW'(1);
            end
         end

         ST_OUTPUT: begin
            state_d = ST_FILL;
         end

         default: begin
            state_d = ST_FILL;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_FILL;
         p_q        <= '0;
         k_q        <= '0;
         acc_q      <= '0;
         wait_q     <= '0;
         valid_in_q <= 1'b0;
         signal_1_q <= '0;
         signal_2_q <= '0;
         signal_3_q <= '0;
         signal_4_q <= '0;
         y_valid_q  <= 1'b0;
         y_data_q   <= '0;
         error_q    <= 1'b0;
         for (int i = 0; i < T; i++) begin
            coef_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         p_q        <= p_d;
         k_q        <= k_d;
         acc_q      <= acc_d;
         wait_q     <= wait_d;
         valid_in_q <= valid_in_d;
         signal_1_q <= signal_1_d;
         signal_2_q <= signal_2_d;
         signal_3_q <= signal_3_d;
         signal_4_q <= signal_4_d;
         y_valid_q  <= y_valid_d;
         y_data_q   <= y_data_d;
         error_q    <= error_d;
         coef_q     <= coef_d;
      end
   end

   assign valid_in = valid_in_q;
   assign signal_1 = signal_1_q;
   assign signal_2 = signal_2_q;
   assign signal_3 = signal_3_q;
   assign signal_4 = signal_4_q;
   assign y_valid  = y_valid_q;
   assign y_data   = y_data_q;
   assign error    = error_q;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mac_operand_sequencer
// Drives mac_operand_sequencer against a behavioural MAC and compares every
// filtered output with a symmetric-FIR reference model kept in the bench.
// -----------------------------------------------------------------------------
module tb_mac_operand_sequencer;

   localparam int W       = 16;
   localparam int N       = 31;
   localparam int M       = 2;
   localparam int TIMEOUT = 64;
   localparam int L       = 4;
   localparam int T       = (N + 1) / 2;
   localparam int CW      = $clog2(T);
   localparam int LAT     = T * (L + 1) + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [W-1:0]  sample_in = '0;
   logic          sample_valid = 1'b0;
   logic          sample_ready;
   logic          coef_we = 1'b0;
   logic [CW-1:0] coef_addr = '0;
   logic [W-1:0]  coef_data = '0;
   logic          valid_in;
   logic [W-1:0]  signal_1, signal_2, signal_3, signal_4;
   logic          valid_out;
   logic [W-1:0]  data_out;
   logic          y_valid;
   logic [W-1:0]  y_data;
   logic          error;

   mac_operand_sequencer #(
      .SAMPLE_WIDTH (W),
      .N            (N),
      .M            (M),
      .TIMEOUT      (TIMEOUT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .coef_we      (coef_we),
      .coef_addr    (coef_addr),
      .coef_data    (coef_data),
      .valid_in     (valid_in),
      .signal_1     (signal_1),
      .signal_2     (signal_2),
      .signal_3     (signal_3),
      .signal_4     (signal_4),
      .valid_out    (valid_out),
      .data_out     (data_out),
      .y_valid      (y_valid),
      .y_data       (y_data),
      .error        (error)
   );

   always #5 clk = ~clk;

   // Behavioural MAC: an operation takes L cycles counted from the first cycle
   // valid_in is high, the result being presented in the L-th of them.  While
   // valid_in is low it may emit spurious junk results, which must be ignored.
   int           mac_cnt;
   logic         mac_en = 1'b1;
   logic         spur = 1'b0;
   logic         spur_en = 1'b0;
   logic [W-1:0] spur_data = '0;
   logic [W-1:0] mac_sum, mac_res;

   always @(posedge clk or posedge reset) begin
      if (reset) mac_cnt <= 0;
      else if (valid_in && !valid_out) mac_cnt <= mac_cnt + 1;
      else mac_cnt <= 0;
   end

   assign mac_sum   = signal_1 + signal_2;
   assign mac_res   = mac_sum * signal_3 + signal_4;
   assign valid_out = valid_in ? (mac_en && (mac_cnt == L - 1)) : spur;
   assign data_out  = valid_in ? mac_res : spur_data;

   // Reference model: sample history (newest first), coefficient image,
   // decimation phase, and queues of expected outputs with their trigger cycle.
   logic [W-1:0] hist   [N];
   logic [W-1:0] coef_m [T];
   int           phase;
   logic [W-1:0] exp_q[$];
   int           acc_cyc_q[$];
   int           cyc, y_cnt;
   logic [W-1:0] last_y;
   bit           last_acc;
   int           checks, errors;

   // Symmetric FIR: tap i and tap N-1-i share one coefficient; sums wrap mod 2^W.
   function automatic logic [W-1:0] ref_y();
      logic [W-1:0] s;
      int c;
      s = '0;
      for (int i = 0; i < N; i++) begin
         c = (i < N - 1 - i) ? i : N - 1 - i;
         s = s + hist[i] * coef_m[c];
      end
      return s;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) hist[i] = '0;
      for (int i = 0; i < T; i++) coef_m[i] = '0;
      phase = 0;
      exp_q.delete();
      acc_cyc_q.delete();
   endtask

   // One clock cycle: capture handshakes before the edge, update the model,
   // then check outputs of the new cycle 1 time unit after the edge.
   task automatic tick();
      bit            acc, cw, pv, pvo;
      logic [W-1:0]  v, cd;
      logic [CW-1:0] ca;
      logic [63:0]   pops;
      int            pc;
      acc  = sample_valid && sample_ready;
      v    = sample_in;
      cw   = coef_we;
      ca   = coef_addr;
      cd   = coef_data;
      pv   = valid_in;
      pvo  = valid_out;
      pops = {signal_1, signal_2, signal_3, signal_4};
      pc   = cyc;
      @(posedge clk);
      #1;
      cyc++;
      if (cw && ca < T) coef_m[ca] = cd;
      last_acc = acc;
      if (acc) begin
         for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = v;
         phase++;
         if (phase == M) begin
            phase = 0;
            exp_q.push_back(ref_y());
            acc_cyc_q.push_back(pc);
         end
      end
      if (y_valid) begin
         y_cnt++;
         last_y = y_data;
         if (exp_q.size() == 0) begin
            check("y_valid_unexpected", 64'(y_valid), 64'd0);
         end else begin
            check("y_data", 64'(y_data), 64'(exp_q.pop_front()));
            check("y_latency", 64'(cyc - acc_cyc_q.pop_front()), 64'(LAT));
         end
      end
      if (valid_in || y_valid) check("sample_ready_busy", 64'(sample_ready), 64'd0);
      if (valid_in && pv && !pvo)
         check("operands_stable", {signal_1, signal_2, signal_3, signal_4}, pops);
      spur      = spur_en && ($urandom_range(0, 1) == 1);
      spur_data = W'($urandom);
   endtask

   task automatic write_coef(input int addr, input logic [W-1:0] data);
      coef_we   = 1'b1;
      coef_addr = CW'(addr);
      coef_data = data;
      tick();
      coef_we   = 1'b0;
   endtask

   // Offer n samples; values are held until accepted. Optional idle gaps
   // between samples; otherwise sample_valid stays high throughout.
   task automatic send(input int n, input bit rnd, input logic [W-1:0] val, input bit gaps);
      int sent, budget, idle;
      sent   = 0;
      budget = 0;
      sample_in = rnd ? W'($urandom) : val;
      while (sent < n && budget < 20000) begin
         sample_valid = 1'b1;
         tick();
         budget++;
         if (last_acc) begin
            sent++;
            sample_in = rnd ? W'($urandom) : val;
            idle = gaps ? int'($urandom_range(0, 3)) : 0;
            while (idle > 0 && sent < n) begin
               sample_valid = 1'b0;
               tick();
               idle--;
            end
         end
      end
      sample_valid = 1'b0;
      check("send_accepted", 64'(sent), 64'(n));
   endtask

   task automatic drain();
      int b;
      b = 0;
      while (exp_q.size() != 0 && b < 3000) begin
         tick();
         b++;
      end
      check("drain_done", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic run_until(input int target);
      while (cyc < target) tick();
   endtask

   initial begin
      int y0, c0;
      logic [W-1:0] e;
      checks = 0;
      errors = 0;
      cyc    = 0;
      y_cnt  = 0;
      last_y = '0;
      model_clear();

      // Reset values, then first cycle after release.
      #1;
      check("rst_valid_in", 64'(valid_in), 64'd0);
      check("rst_operands", {signal_1, signal_2, signal_3, signal_4}, 64'd0);
      check("rst_y_valid", 64'(y_valid), 64'd0);
      check("rst_y_data", 64'(y_data), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("ready_after_release", 64'(sample_ready), 64'd1);

      // Unit coefficients, 32 unit samples with valid held high.
      for (int k = 0; k < T; k++) write_coef(k, 16'd1);
      y0 = y_cnt;
      send(32, 1'b0, 16'd1, 1'b0);
      drain();
      check("ones_last_y", 64'(last_y), 64'd31);
      check("ones_output_count", 64'(y_cnt - y0), 64'd16);

      // Random samples streamed back-to-back: no loss or duplication.
      y0 = y_cnt;
      send(40, 1'b1, '0, 1'b0);
      drain();
      check("stream_output_count", 64'(y_cnt - y0), 64'd20);

      // Largest positive values everywhere: wraps modulo 2^16.
      for (int k = 0; k < T; k++) write_coef(k, 16'h7FFF);
      send(32, 1'b0, 16'h7FFF, 1'b0);
      drain();
      check("max_last_y", 64'(last_y), 64'd31);

      // Random coefficients, gapped samples, spurious MAC results outside WAIT.
      for (int k = 0; k < T; k++) write_coef(k, W'($urandom));
      spur_en = 1'b1;
      send(40, 1'b1, '0, 1'b1);
      drain();

      // Coefficient write timing: only tap 5 is non-zero (initially 7).
      for (int k = 0; k < T; k++) write_coef(k, (k == 5) ? 16'd7 : 16'd0);
      send(2, 1'b1, '0, 1'b0);
      c0 = acc_cyc_q[acc_cyc_q.size()-1];
      e  = hist[5] + hist[25];
      e  = e * 16'd3;
      exp_q[exp_q.size()-1] = e;
      run_until(c0 + 12);                 // tap 2 waiting: new value reaches tap 5
      write_coef(5, 16'd3);
      run_until(c0 + 27);                 // first WAIT cycle of tap 5
      check("tap5_coef_new", 64'(signal_3), 64'd3);
      drain();

      send(2, 1'b1, '0, 1'b0);
      c0 = acc_cyc_q[acc_cyc_q.size()-1];
      e  = hist[5] + hist[25];
      e  = e * 16'd3;
      exp_q[exp_q.size()-1] = e;
      run_until(c0 + 26);                 // tap 5 ISSUE cycle: write must not be seen
      write_coef(5, 16'd9);
      check("tap5_coef_old", 64'(signal_3), 64'd3);
      drain();
      send(2, 1'b1, '0, 1'b0);            // later run uses 9
      drain();

      // MAC never answers: timeout after 64 WAIT cycles, no output.
      mac_en = 1'b0;
      y0 = y_cnt;
      send(2, 1'b1, '0, 1'b0);
      c0 = acc_cyc_q[acc_cyc_q.size()-1];
      run_until(c0 + 65);
      check("timeout_not_yet_error", 64'(error), 64'd0);
      check("timeout_not_yet_valid_in", 64'(valid_in), 64'd1);
      tick();
      check("timeout_error", 64'(error), 64'd1);
      check("timeout_valid_in", 64'(valid_in), 64'd0);
      check("timeout_ready", 64'(sample_ready), 64'd1);
      exp_q.delete();
      acc_cyc_q.delete();
      repeat (120) tick();
      check("timeout_no_y", 64'(y_cnt - y0), 64'd0);
      mac_en = 1'b1;
      send(2, 1'b1, '0, 1'b0);
      drain();
      check("error_sticky", 64'(error), 64'd1);
      check("after_timeout_y_count", 64'(y_cnt - y0), 64'd1);

      // Reset asserted during WAIT.
      send(2, 1'b1, '0, 1'b0);
      c0 = acc_cyc_q[acc_cyc_q.size()-1];
      run_until(c0 + 3);
      reset = 1'b1;
      #1;
      check("midrst_valid_in", 64'(valid_in), 64'd0);
      check("midrst_operands", {signal_1, signal_2, signal_3, signal_4}, 64'd0);
      check("midrst_y_valid", 64'(y_valid), 64'd0);
      check("midrst_y_data", 64'(y_data), 64'd0);
      check("midrst_error", 64'(error), 64'd0);
      check("midrst_ready", 64'(sample_ready), 64'd1);
      model_clear();
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("midrst_ready_after_release", 64'(sample_ready), 64'd1);
      for (int k = 0; k < T; k++) write_coef(k, W'($urandom));
      y0 = y_cnt;
      send(1, 1'b1, '0, 1'b0);
      repeat (100) tick();
      check("midrst_no_early_y", 64'(y_cnt - y0), 64'd0);
      send(1, 1'b1, '0, 1'b0);
      drain();
      check("midrst_first_y", 64'(y_cnt - y0), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
